// File: rtl/rr_packed_logb_unpacker.sv
// rtl/rr_packed_logb_unpacker.sv - pipelined unpacker of gap-free packed logb channel records
//
// A record arrives with its present channels packed back to back from bit 0.
// Stage k peels channel k off the bottom of the residual and drops it into
// its fixed slot. The last stage drives the outputs directly. Up to eight
// channels are summed into FULL_WIDTH.
module rr_packed_logb_unpacker #(
    parameter int CHANNEL_CNT = 4,
    parameter int CHANNEL_WIDTHS [CHANNEL_CNT] = '{32, 64, 8, 16},
    localparam int FULL_WIDTH =
          ((CHANNEL_CNT > 0) ? CHANNEL_WIDTHS[0] : 0)
        + ((CHANNEL_CNT > 1) ? CHANNEL_WIDTHS[(CHANNEL_CNT > 1) ? 1 : 0] : 0)
        + ((CHANNEL_CNT > 2) ? CHANNEL_WIDTHS[(CHANNEL_CNT > 2) ? 2 : 0] : 0)
        + ((CHANNEL_CNT > 3) ? CHANNEL_WIDTHS[(CHANNEL_CNT > 3) ? 3 : 0] : 0)
        + ((CHANNEL_CNT > 4) ? CHANNEL_WIDTHS[(CHANNEL_CNT > 4) ? 4 : 0] : 0)
        + ((CHANNEL_CNT > 5) ? CHANNEL_WIDTHS[(CHANNEL_CNT > 5) ? 5 : 0] : 0)
        + ((CHANNEL_CNT > 6) ? CHANNEL_WIDTHS[(CHANNEL_CNT > 6) ? 6 : 0] : 0)
        + ((CHANNEL_CNT > 7) ? CHANNEL_WIDTHS[(CHANNEL_CNT > 7) ? 7 : 0] : 0),
    localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FULL_WIDTH-1:0]   in_data,
    input  logic [OFFSET_WIDTH-1:0] in_len,
    input  logic [CHANNEL_CNT-1:0]  in_chan_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHANNEL_CNT-1:0]  out_chan_valid,
    output logic [FULL_WIDTH-1:0]   out_data,
    output logic                    out_len_err,
    output logic                    err_sticky,
    output logic [31:0]             record_cnt
);

    localparam int LAST = CHANNEL_CNT - 1;

    // Bit position of channel k inside the unpacked output word.
    function automatic int chan_offset(input int k);
        int s;
        s = 0;
        for (int i = 0; i < CHANNEL_CNT; i++) begin
            if (i < k) begin
                s = s + CHANNEL_WIDTHS[i];
            end
        end
        return s;
    endfunction

    // Mask with the low n bits set.
    function automatic logic [FULL_WIDTH-1:0] low_mask(input int n);
        logic [FULL_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < FULL_WIDTH; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Stage registers
    logic                    st_valid [CHANNEL_CNT];
    logic [FULL_WIDTH-1:0]   st_resid [CHANNEL_CNT];
    logic [OFFSET_WIDTH-1:0] st_len   [CHANNEL_CNT];
    logic [CHANNEL_CNT-1:0]  st_chan  [CHANNEL_CNT];
    logic [FULL_WIDTH-1:0]   st_data  [CHANNEL_CNT];
    logic                    st_err   [CHANNEL_CNT];

    // What each stage sees at its input
    logic                    src_valid [CHANNEL_CNT];
    logic [FULL_WIDTH-1:0]   src_resid [CHANNEL_CNT];
    logic [OFFSET_WIDTH-1:0] src_len   [CHANNEL_CNT];
    logic [CHANNEL_CNT-1:0]  src_chan  [CHANNEL_CNT];
    logic [FULL_WIDTH-1:0]   src_data  [CHANNEL_CNT];
    logic                    src_err   [CHANNEL_CNT];

    // What each stage will capture on advance
    logic                    nxt_valid [CHANNEL_CNT];
    logic [FULL_WIDTH-1:0]   nxt_resid [CHANNEL_CNT];
    logic [OFFSET_WIDTH-1:0] nxt_len   [CHANNEL_CNT];
    logic [CHANNEL_CNT-1:0]  nxt_chan  [CHANNEL_CNT];
    logic [FULL_WIDTH-1:0]   nxt_data  [CHANNEL_CNT];
    logic                    nxt_err   [CHANNEL_CNT];

    logic advance;

    // The whole pipe moves together; it only stops when the output is held.
    always_comb begin
        advance  = !st_valid[LAST] || out_ready;
        in_ready = advance;
    end

    // Stage 0 is fed by the input port, every later stage by its predecessor.
    always_comb begin
        src_valid[0] = in_valid;
        src_resid[0] = in_data;
        src_len[0]   = in_len;
        src_chan[0]  = in_chan_valid;
        src_data[0]  = '0;
        src_err[0]   = 1'b0;
        for (int k = 1; k < CHANNEL_CNT; k++) begin
            src_valid[k] = st_valid[k-1];
            src_resid[k] = st_resid[k-1];
            src_len[k]   = st_len[k-1];
            src_chan[k]  = st_chan[k-1];
            src_data[k]  = st_data[k-1];
            src_err[k]   = st_err[k-1];
        end
    end

    // Per-stage extraction: peel channel k off the residual when present.
    always_comb begin
        for (int k = 0; k < CHANNEL_CNT; k++) begin
            nxt_valid[k] = src_valid[k];
            nxt_chan[k]  = src_chan[k];
            nxt_resid[k] = src_resid[k];
            nxt_len[k]   = src_len[k];
            nxt_err[k]   = src_err[k];
            nxt_data[k]  = src_data[k] & ~(low_mask(CHANNEL_WIDTHS[k]) << chan_offset(k));
            if (src_chan[k][k]) begin
                nxt_data[k]  = nxt_data[k]
                             | ((src_resid[k] & low_mask(CHANNEL_WIDTHS[k])) << chan_offset(k));
                nxt_resid[k] = src_resid[k] >> CHANNEL_WIDTHS[k];
                if (int'(src_len[k]) < CHANNEL_WIDTHS[k]) begin
                    // Declared length ran out before this channel: flag it,
                    // clamp at zero, but still pull the bits out.
                    nxt_err[k] = 1'b1;
                    nxt_len[k] = '0;
                end else begin
                    nxt_len[k] = src_len[k] - OFFSET_WIDTH'(CHANNEL_WIDTHS[k]);
                end
            end
            // Anything left over after the last channel means the length lied.
            if ((k == LAST) && (nxt_len[k] != '0)) begin
                nxt_err[k] = 1'b1;
            end
        end
    end

    // Pipeline registers: shift on advance, otherwise hold everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CHANNEL_CNT; k++) begin
                st_valid[k] <= 1'b0;
                st_resid[k] <= '0;
                st_len[k]   <= '0;
                st_chan[k]  <= '0;
                st_data[k]  <= '0;
                st_err[k]   <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < CHANNEL_CNT; k++) begin
                st_valid[k] <= nxt_valid[k];
                st_resid[k] <= nxt_resid[k];
                st_len[k]   <= nxt_len[k];
                st_chan[k]  <= nxt_chan[k];
                st_data[k]  <= nxt_data[k];
                st_err[k]   <= nxt_err[k];
            end
        end
    end

    // Delivery bookkeeping: count handshakes and latch any length error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            record_cnt <= '0;
            err_sticky <= 1'b0;
        end else if (st_valid[LAST] && out_ready) begin
            record_cnt <= record_cnt + 32'd1;
            if (st_err[LAST]) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign out_valid      = st_valid[LAST];
    assign out_chan_valid = st_chan[LAST];
    assign out_data       = st_data[LAST];
    assign out_len_err    = st_err[LAST];

endmodule

// File: doc/rr_packed_logb_unpacker.md
RR_PACKED_LOGB_UNPACKER -- requirements
Module: rr_packed_logb_unpacker

Interface
REQ-001 SHALL have parameter CHANNEL_CNT, default 4: number of logb channels.
REQ-002 SHALL have parameter CHANNEL_WIDTHS, default '{32,64,8,16}: payload width of channel k at index k, each 1..512.
REQ-003 SHALL have localparam FULL_WIDTH = sum of CHANNEL_WIDTHS (default 120) and OFFSET_WIDTH = $clog2(FULL_WIDTH+1) (default 7).
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  packed record present.
REQ-008 in_ready  output  1  record accepted when in_valid && in_ready.
REQ-009 in_data  input  FULL_WIDTH  valid-channel payloads concatenated in ascending channel order from bit 0, no gaps.
REQ-010 in_len  input  OFFSET_WIDTH  total valid bits in in_data.
REQ-011 in_chan_valid  input  CHANNEL_CNT  bit k set: channel k present in record.
REQ-012 out_valid  output  1  unpacked record present.
REQ-013 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-014 out_chan_valid  output  CHANNEL_CNT  copy of record's in_chan_valid.
REQ-015 out_data  output  FULL_WIDTH  channel k at fixed offset sum(CHANNEL_WIDTHS[0..k-1]); absent channels zero.
REQ-016 out_len_err  output  1  record's length inconsistent with channel set.
REQ-017 err_sticky  output  1  set by any delivered record with out_len_err; cleared only by reset.
REQ-018 record_cnt  output  32  number of records delivered.

Function
REQ-019 SHALL implement CHANNEL_CNT register stages; stage k extracts channel k; stage CHANNEL_CNT-1 drives the outputs directly.
REQ-020 Each stage SHALL hold: valid, residual data (FULL_WIDTH), residual len (OFFSET_WIDTH), chan_valid, unpacked data, err.
REQ-021 Stage k with chan_valid[k]=1 SHALL write residual[0 +: W_k] to slot k, shift residual right by W_k (zero fill), and subtract W_k from len.
REQ-022 Stage k with chan_valid[k]=0 SHALL write zero to slot k and pass residual and len unchanged.
REQ-023 If residual len < W_k with chan_valid[k]=1, SHALL set err and saturate len at 0; extraction still occurs.
REQ-024 Final stage SHALL set err if residual len != 0 after its extraction; out_len_err = final err.
REQ-025 advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, no dependence on in_valid).
REQ-026 On advance all stages SHALL shift one position; stage 0 loads the input, with valid = in_valid.
REQ-027 Without advance every stage SHALL hold all contents; outputs stay stable while out_valid && !out_ready.
REQ-028 Latency SHALL be exactly CHANNEL_CNT cycles from acceptance to out_valid when out_ready is held 1; throughput one record per cycle.
REQ-029 Record with in_chan_valid all zero SHALL pass through: out_data 0, out_len_err = (in_len != 0).
REQ-030 Bubble stages (valid=0) SHALL advance without modifying err_sticky or record_cnt.
REQ-031 record_cnt SHALL increment by 1 on each out_valid && out_ready and wrap from 2^32-1 to 0.
REQ-032 err_sticky SHALL set on out_valid && out_ready && out_len_err.
REQ-033 Extra in_data bits above in_len SHALL be ignored except as reflected by REQ-024.

Reset
REQ-034 While rst=1: all stage valid bits, out_valid, out_len_err, err_sticky, record_cnt, and all data/len/chan_valid registers SHALL be 0; in_ready=1.
REQ-035 rst asserted mid-operation SHALL discard all in-flight records; no output record appears for them after release.
REQ-036 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-037 All channels: chan_valid=4'b1111, len=120, in_data=random D -> 4 cycles later out_data=D, out_len_err=0, record_cnt=1.
REQ-038 Sparse: chan_valid=4'b1010, in_data[63:0]=A, in_data[79:64]=B, len=80 -> out_data[95:32]=A, out_data[119:104]=B, other bits 0, out_len_err=0.
REQ-039 Backpressure: 6 back-to-back records, out_ready=0 for cycles 5-9 -> in_ready=0 during stall, all 6 delivered in order unchanged, record_cnt=6.
REQ-040 Length error: chan_valid=4'b0100, len=16 -> out_len_err=1, err_sticky=1 after handshake; next record chan_valid=4'b0001, len=32 -> out_len_err=0, err_sticky stays 1.
REQ-041 Underflow: chan_valid=4'b0011, len=40 -> out_len_err=1, slot 0 = in_data[31:0].
REQ-042 Reset mid-flight: 3 records accepted, rst pulsed 1 cycle -> out_valid=0, record_cnt=0, err_sticky=0, no stale record emerges in next 8 cycles.
